// File: rtl/aes_sched_pkg.sv
// Shared encodings and single-SBox GF(2^8) arithmetic for the
// byte-serial AES unit and the scheduler that shares it.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_BUSY  = 2'd2
  } sched_state_e;

  localparam int AES_LAT  = 4;
  localparam int NREQ_MAX = 4;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x,
    input logic       dec
  );
    logic [7:0] r1, r2, r3, r4, r6, t;
    r1 = rl(x);
    r2 = rl(r1);
    r3 = rl(r2);
    r4 = rl(r3);
    r6 = rl(rl(r4));
    if (dec) begin
      t = r1 ^ r3 ^ r6 ^ 8'h05;
      return gf_inv(t);
    end
    t = gf_inv(x);
    r1 = rl(t);
    r2 = rl(r1);
    r3 = rl(r2);
    r4 = rl(r3);
    return t ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_v1.sv
// Size-optimised AES SubBytes unit: one SBox, one byte per cycle,
// result and ready pulse in the fourth cycle after valid.
module aes_v1
  import aes_sched_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic        dec,
  output logic        ready,
  output logic [31:0] rd
);

  logic        active;
  logic [1:0]  idx;
  logic [23:0] acc;
  logic [7:0]  b_in;
  logic [7:0]  sb;

  assign b_in  = rs1[{idx, 3'b000} +: 8];
  assign sb    = sbox(b_in, dec);
  assign ready = active && (idx == 2'(AES_LAT - 1));
  assign rd    = ready ? {sb, acc} : '0;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      active <= 1'b0;
      idx    <= '0;
      acc    <= '0;
    end else if (valid) begin
      active <= 1'b1;
      idx    <= '0;
    end else if (active) begin
      unique case (idx)
        2'd0:    acc[7:0]   <= sb;
        2'd1:    acc[15:8]  <= sb;
        2'd2:    acc[23:16] <= sb;
        default: active     <= 1'b0;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/rr_arb_mask.sv
// Combinational round-robin picker: first unmasked request at or
// after the pointer wins.
module rr_arb_mask #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDXW-1:0] ptr,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  logic [NREQ-1:0] eff;

  assign eff = req & ~mask;

  always_comb begin
    int j;
    logic [IDXW-1:0] sel;
    j         = 0;
    sel       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // walk from furthest to nearest so the nearest hit lands last
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      sel = IDXW'(j);
      if (eff[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/aes_v1_sched.sv
// Round-robin scheduler sharing one byte-serial aes_v1 between
// NREQ requesters; operands are latched at grant.
module aes_v1_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_dec,
  input  logic [32*NREQ-1:0]   req_rs1,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          req_rd,
  output logic                 busy
);

  sched_state_e    state, state_nx;
  logic [IDXW-1:0] grant, ptr, gnt_idx;
  logic [NREQ-1:0] mask;
  logic            gnt_valid, done, latch;
  logic            op_dec;
  logic [31:0]     op_rs1;
  logic            aes_valid, aes_ready;
  logic [31:0]     aes_rd;

  assign done      = (state == SCHED_BUSY) && aes_ready;
  // the finishing requester still shows its stale valid this cycle
  assign mask      = done ? (NREQ'(1) << grant) : '0;
  assign req_ready = mask;
  assign req_rd    = done ? aes_rd : '0;
  assign busy      = (state != SCHED_IDLE);

  rr_arb_mask #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req       (req_valid),
    .mask      (mask),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  aes_v1 u_aes (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .valid    (aes_valid),
    .rs1      (op_rs1),
    .dec      (op_dec),
    .ready    (aes_ready),
    .rd       (aes_rd)
  );

  always_comb begin
    state_nx  = state;
    latch     = 1'b0;
    aes_valid = 1'b0;
    unique case (state)
      SCHED_IDLE: begin
        if (gnt_valid) begin
          latch    = 1'b1;
          state_nx = SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        aes_valid = 1'b1;
        state_nx  = SCHED_BUSY;
      end
      SCHED_BUSY: begin
        if (aes_ready) begin
          latch    = gnt_valid;
          state_nx = gnt_valid ? SCHED_ISSUE : SCHED_IDLE;
        end
      end
      default: state_nx = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state  <= SCHED_IDLE;
      grant  <= '0;
      ptr    <= '0;
      op_rs1 <= '0;
      op_dec <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        grant  <= gnt_idx;
        ptr    <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        op_rs1 <= req_rs1[{gnt_idx, 5'b00000} +: 32];
        op_dec <= req_dec[gnt_idx];
      end
    end
  end

  a_rdy_in_busy : assert property (
    @(posedge g_clk) disable iff (!g_resetn)
    aes_ready |-> (state == SCHED_BUSY)
  );

endmodule

// File: tb/tb_aes_v1_sched.sv
// Randomised and directed bench for aes_v1_sched against a
// table-driven SubBytes model and a round-robin service model.
module tb_aes_v1_sched;

  localparam int NREQ = 2;

  logic               g_clk = 1'b0;
  logic               g_resetn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_dec = '0;
  logic [32*NREQ-1:0] req_rs1 = '0;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        req_rd;
  logic               busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] fwd [256];
  logic [7:0] inv [256];

  int          m_idx = -1;
  int          m_done = -1;
  int          m_last = -1;
  logic [31:0] m_exp = '0;

  int          log_cyc[$];
  int          log_idx[$];
  logic [31:0] log_rd[$];

  always #5 g_clk = ~g_clk;

  aes_v1_sched #(.NREQ(NREQ)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_dec   (req_dec),
    .req_rs1   (req_rs1),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .busy      (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic bitof(input logic [NREQ-1:0] v, input int j);
    return 1'(v >> j);
  endfunction

  function automatic logic [7:0] xmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      logic [7:0] s;
      v = '0;
      for (int y = 1; y < 256; y++)
        if (xmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int b = 0; b < 8; b++)
        s[3'(b)] = v[3'(b)] ^ v[3'(b + 4)] ^ v[3'(b + 5)]
                 ^ v[3'(b + 6)] ^ v[3'(b + 7)] ^ c[3'(b)];
      fwd[8'(x)] = s;
      inv[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] ref_word(
    input logic [31:0] w,
    input logic        d
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = d ? inv[w[8*b +: 8]] : fwd[w[8*b +: 8]];
    return r;
  endfunction

  task automatic issue(input int i, input logic [31:0] w, input logic d);
    logic [NREQ-1:0] b;
    b = NREQ'(1) << i;
    req_valid = req_valid | b;
    req_rs1[32*i +: 32] = w;
    req_dec = d ? (req_dec | b) : (req_dec & ~b);
  endtask

  // one clock: update the service model, compare, retire pulses
  task automatic step();
    logic [NREQ-1:0]    pv, pd, exp_rdy;
    logic [32*NREQ-1:0] pr;
    logic [31:0]        exp_rd;
    logic               prst;
    int                 t, msk, j;
    pv = req_valid;
    pd = req_dec;
    pr = req_rs1;
    prst = g_resetn;
    t = cyc;
    @(posedge g_clk);
    #1;
    cyc++;
    if (!prst) begin
      m_idx = -1;
      m_done = -1;
      m_last = -1;
    end else if (m_idx < 0 || t == m_done) begin
      msk = (t == m_done) ? m_idx : -1;
      m_idx = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_last + 1 + k) % NREQ;
        if (m_idx < 0 && bitof(pv, j) && j != msk) begin
          m_idx = j;
          m_last = j;
          m_done = t + 5;
          m_exp = ref_word(pr[32*j +: 32], bitof(pd, j));
        end
      end
    end
    exp_rdy = '0;
    exp_rd = '0;
    if (m_idx >= 0 && cyc == m_done) begin
      exp_rdy = NREQ'(1) << m_idx;
      exp_rd = m_exp;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("req_rd", req_rd, exp_rd);
    chk("busy", 32'(busy), 32'(m_idx >= 0));
    if (req_ready != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (bitof(req_ready, k)) begin
          log_cyc.push_back(cyc);
          log_idx.push_back(k);
          log_rd.push_back(req_rd);
        end
      req_valid = req_valid & ~req_ready;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_idx.delete();
    log_rd.delete();
  endtask

  task automatic exp_done(
    input string       tag,
    input int          k,
    input int          c,
    input int          idx,
    input logic [31:0] rd
  );
    chk({tag, "_seen"}, 32'(log_cyc.size() > k), 32'd1);
    if (log_cyc.size() > k) begin
      chk({tag, "_cyc"}, 32'(log_cyc[k]), 32'(c));
      chk({tag, "_idx"}, 32'(log_idx[k]), 32'(idx));
      chk({tag, "_rd"}, log_rd[k], rd);
    end
  endtask

  initial begin
    int          c0;
    logic [31:0] w;
    logic [31:0] e;
    build_tables();

    run(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", req_rd, 32'd0);
    g_resetn = 1'b1;
    run(2);

    clear_log();
    c0 = cyc;
    issue(0, 32'h53020100, 1'b0);
    chk("enc_c0_busy", 32'(busy), 32'd0);
    run(8);
    exp_done("enc", 0, c0 + 5, 0, 32'hED777C63);

    clear_log();
    c0 = cyc;
    issue(1, 32'hED777C63, 1'b1);
    run(8);
    exp_done("dec", 0, c0 + 5, 1, 32'h53020100);

    clear_log();
    c0 = cyc;
    issue(0, 32'h00000000, 1'b0);
    issue(1, 32'h01010101, 1'b0);
    run(14);
    exp_done("cont0", 0, c0 + 5, 0, 32'h63636363);
    exp_done("cont1", 1, c0 + 10, 1, 32'h7C7C7C7C);

    clear_log();
    c0 = cyc;
    issue(0, $urandom, 1'($urandom));
    issue(1, $urandom, 1'($urandom));
    for (int s = 0; s < 60 && log_cyc.size() < 8; s++) begin
      step();
      for (int k = 0; k < NREQ; k++)
        if (!bitof(req_valid, k)) issue(k, $urandom, 1'($urandom));
    end
    chk("fair_count", 32'(log_cyc.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_cyc.size(); k++) begin
      chk("fair_idx", 32'(log_idx[k]), 32'(k % 2));
      chk("fair_cyc", 32'(log_cyc[k]), 32'(c0 + 5 * (k + 1)));
    end
    run(12);

    clear_log();
    c0 = cyc;
    w = $urandom;
    e = ref_word(w, 1'b0);
    issue(0, w, 1'b0);
    run(2);
    req_rs1[31:0] = 32'hFFFFFFFF;
    req_dec[0] = 1'b1;
    run(6);
    exp_done("stable", 0, c0 + 5, 0, e);

    clear_log();
    issue(1, $urandom, 1'b0);
    run(3);
    g_resetn = 1'b0;
    req_valid = '0;
    run(1);
    g_resetn = 1'b1;
    run(6);
    chk("rst_mid_nopulse", 32'(log_cyc.size()), 32'd0);
    chk("rst_mid_idle", 32'(busy), 32'd0);
    c0 = cyc;
    w = $urandom;
    issue(1, w, 1'b1);
    run(7);
    exp_done("post_rst", 0, c0 + 5, 1, ref_word(w, 1'b1));

    clear_log();
    for (int s = 0; s < 400; s++) begin
      step();
      for (int k = 0; k < NREQ; k++)
        if (!bitof(req_valid, k) && $urandom_range(3) == 0)
          issue(k, $urandom, 1'($urandom));
    end
    run(30);
    chk("rand_drained", 32'(req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
